// File: rtl/riscv_mem_arbiter.sv
// Two-to-one arbiter that serializes the core's fetch and data channels onto a
// single memory port: one transaction outstanding, one-bit round-robin on ties.
module riscv_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   PC,
  input  logic                Inst_Req_Valid,
  output logic                Inst_Req_Ack,
  output logic [DATA_W-1:0]   Instruction,
  output logic                Inst_Valid,
  input  logic                Inst_Ack,
  input  logic [ADDR_W-1:0]   Address,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [DATA_W-1:0]   Write_data,
  input  logic [DATA_W/8-1:0] Write_strb,
  output logic                Mem_Req_Ack,
  output logic [DATA_W-1:0]   Read_data,
  output logic                Read_data_Valid,
  input  logic                Read_data_Ack,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_rready
);
  typedef enum logic [1:0] {IDLE, REQ, RWAIT, HOLD} st_t;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  st_t  st, st_n;
  logic own, last;
  logic inst_pend, data_pend;
  logic grant, grant_data, hs, cap, done;

  assign inst_pend = Inst_Req_Valid;
  assign data_pend = MemRead | MemWrite;

  always_comb begin
    st_n       = st;
    grant      = 1'b0;
    grant_data = 1'b0;
    hs         = 1'b0;
    cap        = 1'b0;
    done       = 1'b0;
    case (st)
      IDLE: begin
        if (inst_pend || data_pend) begin
          grant      = 1'b1;
          // On a tie the channel that did not win last time goes first.
          grant_data = data_pend && (!inst_pend || last == OWN_INST);
          st_n       = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          hs   = 1'b1;
          st_n = mem_wen ? IDLE : RWAIT;
        end
      end
      RWAIT: begin
        if (mem_rvalid) begin
          cap  = 1'b1;
          st_n = HOLD;
        end
      end
      HOLD: begin
        if ((own == OWN_DATA) ? Read_data_Ack : Inst_Ack) begin
          done = 1'b1;
          st_n = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st              <= IDLE;
      own             <= OWN_INST;
      last            <= OWN_DATA;
      mem_req_valid   <= 1'b0;
      mem_addr        <= '0;
      mem_wen         <= 1'b0;
      mem_wdata       <= '0;
      mem_wstrb       <= '0;
      mem_rready      <= 1'b0;
      Inst_Req_Ack    <= 1'b0;
      Mem_Req_Ack     <= 1'b0;
      Inst_Valid      <= 1'b0;
      Read_data_Valid <= 1'b0;
      Instruction     <= '0;
      Read_data       <= '0;
    end else begin
      st           <= st_n;
      Inst_Req_Ack <= hs && (own == OWN_INST);
      Mem_Req_Ack  <= hs && (own == OWN_DATA);
      if (grant) begin
        own           <= grant_data;
        last          <= grant_data;
        mem_req_valid <= 1'b1;
        mem_addr      <= grant_data ? Address : PC;
        // A simultaneous read and write is treated as a write.
        mem_wen       <= grant_data && MemWrite;
        mem_wdata     <= grant_data ? Write_data : '0;
        mem_wstrb     <= (grant_data && MemWrite) ? Write_strb : '0;
      end
      if (hs) begin
        mem_req_valid <= 1'b0;
        mem_rready    <= !mem_wen;
      end
      if (cap) begin
        mem_rready <= 1'b0;
        if (own == OWN_DATA) begin
          Read_data       <= mem_rdata;
          Read_data_Valid <= 1'b1;
        end else begin
          Instruction <= mem_rdata;
          Inst_Valid  <= 1'b1;
        end
      end
      if (done) begin
        Inst_Valid      <= 1'b0;
        Read_data_Valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level arbitration/memory model.
module tb_riscv_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] PC, Address, mem_addr;
  logic Inst_Req_Valid, Inst_Req_Ack, Inst_Valid, Inst_Ack;
  logic MemRead, MemWrite, Mem_Req_Ack, Read_data_Valid, Read_data_Ack;
  logic [DATA_W-1:0] Instruction, Write_data, Read_data, mem_wdata, mem_rdata;
  logic [STRB_W-1:0] Write_strb, mem_wstrb;
  logic mem_req_valid, mem_req_ready, mem_wen, mem_rvalid, mem_rready;

  riscv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
    .Inst_Req_Ack(Inst_Req_Ack), .Instruction(Instruction), .Inst_Valid(Inst_Valid),
    .Inst_Ack(Inst_Ack), .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
    .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ack(Mem_Req_Ack),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ack(Read_data_Ack),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] dmem [16];
  logic [DATA_W-1:0] ref_mem [16];

  logic [3+2*ADDR_W-ADDR_W+DATA_W+STRB_W+4+2*DATA_W-1:0] all_out;
  assign all_out = {mem_req_valid, mem_wen, mem_rready, mem_addr, mem_wdata, mem_wstrb,
                    Inst_Req_Ack, Mem_Req_Ack, Inst_Valid, Read_data_Valid,
                    Instruction, Read_data};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PC = '0; Inst_Req_Valid = 0; Inst_Ack = 0; Address = '0; MemRead = 0; MemWrite = 0;
    Write_data = '0; Write_strb = '0; Read_data_Ack = 0; mem_req_ready = 0;
    mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] d,
                                              input logic [STRB_W-1:0] s);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < STRB_W; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ADDR_W'(32'h1000 + ($urandom_range(0, 15) << 2));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    n_chk++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_async: outputs=%h required 0", all_out);
    end
    tick();
    tick();
    n_chk++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_held: outputs=%h required 0", all_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    PC = 32'h100; Inst_Req_Valid = 1; mem_req_ready = 1;
    tick();
    n_chk++;
    if (mem_req_valid !== 1 || mem_addr !== 32'h100 || mem_wen !== 0) begin
      n_fail++; $display("FAIL fetch_req: valid=%b addr=%h wen=%b required 1 00000100 0",
                         mem_req_valid, mem_addr, mem_wen);
    end
    tick();
    n_chk++;
    if ({Inst_Req_Ack, Mem_Req_Ack, mem_req_valid, mem_rready} !== 4'b1001) begin
      n_fail++; $display("FAIL fetch_ack: ack/mack/valid/rready=%b required 1001",
                         {Inst_Req_Ack, Mem_Req_Ack, mem_req_valid, mem_rready});
    end
    Inst_Req_Valid = 0; mem_req_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
    tick();
    mem_rvalid = 0;
    n_chk++;
    if (Inst_Valid !== 1 || Instruction !== 32'h00500093 || Inst_Req_Ack !== 0 || mem_rready !== 0) begin
      n_fail++; $display("FAIL fetch_data: ivalid=%b inst=%h ack=%b rready=%b required 1 00500093 0 0",
                         Inst_Valid, Instruction, Inst_Req_Ack, mem_rready);
    end
    Inst_Ack = 1;
    tick();
    Inst_Ack = 0;
    n_chk++;
    if (Inst_Valid !== 0 || Instruction !== 32'h00500093) begin
      n_fail++; $display("FAIL fetch_consume: ivalid=%b inst=%h required 0 00500093",
                         Inst_Valid, Instruction);
    end
  endtask

  task automatic test_store();
    MemWrite = 1; Address = 32'h2004; Write_data = 32'hDEADBEEF; Write_strb = 4'b0011;
    mem_req_ready = 1;
    tick();
    n_chk++;
    if (mem_req_valid !== 1 || mem_wen !== 1 || mem_wstrb !== 4'b0011 ||
        mem_addr !== 32'h2004 || mem_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_req: valid=%b wen=%b strb=%b addr=%h wdata=%h required 1 1 0011 00002004 deadbeef",
                         mem_req_valid, mem_wen, mem_wstrb, mem_addr, mem_wdata);
    end
    tick();
    MemWrite = 0; mem_req_ready = 0;
    n_chk++;
    if ({Mem_Req_Ack, Inst_Req_Ack, mem_req_valid, mem_rready} !== 4'b1000) begin
      n_fail++; $display("FAIL store_ack: mack/iack/valid/rready=%b required 1000",
                         {Mem_Req_Ack, Inst_Req_Ack, mem_req_valid, mem_rready});
    end
    tick();
    n_chk++;
    if ({Mem_Req_Ack, mem_req_valid, mem_rready} !== 3'b000) begin
      n_fail++; $display("FAIL store_done: mack/valid/rready=%b required 000",
                         {Mem_Req_Ack, mem_req_valid, mem_rready});
    end
  endtask

  task automatic test_round_robin();
    logic own_e;
    logic [ADDR_W-1:0] a_e;
    logic [DATA_W-1:0] d;
    do_reset();
    PC = 32'h400; Address = 32'h800; Inst_Req_Valid = 1; MemRead = 1;
    for (int i = 0; i < 3; i++) begin
      own_e = (i == 1);
      a_e = own_e ? 32'h800 : 32'h400;
      d = $urandom;
      tick();
      n_chk++;
      if (mem_req_valid !== 1 || mem_addr !== a_e || mem_wen !== 0) begin
        n_fail++; $display("FAIL rr_grant%0d: valid=%b addr=%h wen=%b required 1 %h 0",
                           i, mem_req_valid, mem_addr, mem_wen, a_e);
      end
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      n_chk++;
      if ({Inst_Req_Ack, Mem_Req_Ack} !== (own_e ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL rr_ack%0d: iack/mack=%b required %b", i,
                           {Inst_Req_Ack, Mem_Req_Ack}, own_e ? 2'b01 : 2'b10);
      end
      mem_rvalid = 1; mem_rdata = d;
      tick();
      mem_rvalid = 0;
      n_chk++;
      if (own_e ? (Read_data_Valid !== 1 || Inst_Valid !== 0 || Read_data !== d)
                : (Inst_Valid !== 1 || Read_data_Valid !== 0 || Instruction !== d)) begin
        n_fail++; $display("FAIL rr_resp%0d: ivalid=%b dvalid=%b inst=%h rdata=%h required data %h owner %0d",
                           i, Inst_Valid, Read_data_Valid, Instruction, Read_data, d, own_e);
      end
      if (own_e) Read_data_Ack = 1; else Inst_Ack = 1;
      tick();
      Read_data_Ack = 0; Inst_Ack = 0;
      n_chk++;
      if ({Inst_Valid, Read_data_Valid, mem_req_valid} !== 3'b000) begin
        n_fail++; $display("FAIL rr_done%0d: ivalid/dvalid/valid=%b required 000", i,
                           {Inst_Valid, Read_data_Valid, mem_req_valid});
      end
    end
    Inst_Req_Valid = 0; MemRead = 0;
  endtask

  task automatic test_backpressure();
    PC = 32'h600; Inst_Req_Valid = 1; mem_req_ready = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (mem_req_valid !== 1 || mem_addr !== 32'h600 || Inst_Req_Ack !== 0) begin
        n_fail++; $display("FAIL bp_stall%0d: valid=%b addr=%h ack=%b required 1 00000600 0",
                           i, mem_req_valid, mem_addr, Inst_Req_Ack);
      end
      tick();
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; Inst_Req_Valid = 0;
    n_chk++;
    if (Inst_Req_Ack !== 1 || mem_req_valid !== 0) begin
      n_fail++; $display("FAIL bp_ack: ack=%b valid=%b required 1 0", Inst_Req_Ack, mem_req_valid);
    end
    tick();
    n_chk++;
    if (Inst_Req_Ack !== 0) begin
      n_fail++; $display("FAIL bp_pulse: ack=%b required 0", Inst_Req_Ack);
    end
    mem_rvalid = 1; mem_rdata = 32'h13;
    tick();
    mem_rvalid = 0; Inst_Ack = 1;
    tick();
    Inst_Ack = 0;
  endtask

  task automatic test_slow_consumer();
    MemRead = 1; Address = 32'h3000; mem_req_ready = 1;
    tick();
    tick();
    MemRead = 0; mem_req_ready = 0;
    PC = 32'h500; Inst_Req_Valid = 1;
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (Read_data_Valid !== 1 || Read_data !== 32'hCAFEF00D || mem_req_valid !== 0) begin
        n_fail++; $display("FAIL slow_hold%0d: dvalid=%b rdata=%h reqvalid=%b required 1 cafef00d 0",
                           i, Read_data_Valid, Read_data, mem_req_valid);
      end
      tick();
    end
    Read_data_Ack = 1;
    tick();
    Read_data_Ack = 0;
    n_chk++;
    if (Read_data_Valid !== 0 || mem_req_valid !== 0 || Read_data !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL slow_release: dvalid=%b reqvalid=%b rdata=%h required 0 0 cafef00d",
                         Read_data_Valid, mem_req_valid, Read_data);
    end
    tick();
    n_chk++;
    if (mem_req_valid !== 1 || mem_addr !== 32'h500) begin
      n_fail++; $display("FAIL slow_next: reqvalid=%b addr=%h required 1 00000500", mem_req_valid, mem_addr);
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; Inst_Req_Valid = 0; mem_rvalid = 1; mem_rdata = 32'h33;
    tick();
    mem_rvalid = 0; Inst_Ack = 1;
    tick();
    Inst_Ack = 0;
  endtask

  task automatic test_reset_rwait();
    PC = 32'h700; Inst_Req_Valid = 1; mem_req_ready = 1;
    tick();
    tick();
    Inst_Req_Valid = 0; mem_req_ready = 0;
    n_chk++;
    if (mem_rready !== 1) begin
      n_fail++; $display("FAIL rst_pre: rready=%b required 1", mem_rready);
    end
    #3;
    rst = 1'b1; mem_rvalid = 1; mem_rdata = 32'h12345678;
    #1;
    n_chk++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL rst_async_rwait: outputs=%h required 0", all_out);
    end
    tick();
    n_chk++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL rst_rvalid_ignored: outputs=%h required 0", all_out);
    end
    rst = 1'b0; mem_rvalid = 0;
    tick();
    PC = 32'h104; Inst_Req_Valid = 1; mem_req_ready = 1;
    tick();
    n_chk++;
    if (mem_req_valid !== 1 || mem_addr !== 32'h104) begin
      n_fail++; $display("FAIL rst_refetch_req: valid=%b addr=%h required 1 00000104", mem_req_valid, mem_addr);
    end
    tick();
    Inst_Req_Valid = 0; mem_req_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00A00113;
    tick();
    mem_rvalid = 0;
    n_chk++;
    if (Inst_Valid !== 1 || Instruction !== 32'h00A00113) begin
      n_fail++; $display("FAIL rst_refetch_data: ivalid=%b inst=%h required 1 00a00113", Inst_Valid, Instruction);
    end
    Inst_Ack = 1;
    tick();
    Inst_Ack = 0;
  endtask

  task automatic test_random();
    bit ip, dp, dw, dr, g, last_m;
    logic [ADDR_W-1:0] pa, da, ea, ra;
    logic [DATA_W-1:0] wd, exp_d;
    logic [STRB_W-1:0] ws, estrb;
    logic ewen;
    int idx;
    do_reset();
    last_m = 1'b1;
    ip = 0; dp = 0; dw = 0; dr = 0;
    pa = '0; da = '0; wd = '0; ws = '0;
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = $urandom;
      dmem[k] = ref_mem[k];
    end
    for (int t = 0; t < 40; t++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin ip = 1; pa = rand_addr(); end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; da = rand_addr(); wd = $urandom; ws = STRB_W'($urandom);
        dw = 1'($urandom); dr = dw ? 1'($urandom) : 1'b1;
      end
      if (!ip && !dp) begin ip = 1; pa = rand_addr(); end
      PC = pa; Inst_Req_Valid = ip; Address = da; MemRead = dp & dr; MemWrite = dp & dw;
      Write_data = wd; Write_strb = ws;
      g = (ip && dp) ? !last_m : dp;
      last_m = g;
      ea = g ? da : pa;
      ewen = g & dw;
      estrb = ewen ? ws : '0;
      tick();
      n_chk++;
      if (mem_req_valid !== 1 || mem_addr !== ea || mem_wen !== ewen || mem_wstrb !== estrb ||
          (ewen && mem_wdata !== wd)) begin
        n_fail++; $display("FAIL rnd_grant%0d: valid=%b addr=%h wen=%b strb=%b wdata=%h required 1 %h %b %b %h",
                           t, mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata, ea, ewen, estrb, wd);
        return;
      end
      for (int s = $urandom_range(0, 3); s > 0; s--) tick();
      n_chk++;
      if (mem_req_valid !== 1 || mem_addr !== ea || Inst_Req_Ack !== 0 || Mem_Req_Ack !== 0) begin
        n_fail++; $display("FAIL rnd_stall%0d: valid=%b addr=%h acks=%b%b required 1 %h 00",
                           t, mem_req_valid, mem_addr, Inst_Req_Ack, Mem_Req_Ack, ea);
      end
      mem_req_ready = 1;
      ra = mem_addr;
      if (mem_wen === 1'b1) dmem[mem_addr[5:2]] = merge(dmem[mem_addr[5:2]], mem_wdata, mem_wstrb);
      tick();
      mem_req_ready = 0;
      n_chk++;
      if ({Inst_Req_Ack, Mem_Req_Ack} !== (g ? 2'b01 : 2'b10) || mem_rready !== !ewen || mem_req_valid !== 0) begin
        n_fail++; $display("FAIL rnd_ack%0d: acks=%b rready=%b valid=%b required %b %b 0",
                           t, {Inst_Req_Ack, Mem_Req_Ack}, mem_rready, mem_req_valid,
                           g ? 2'b01 : 2'b10, !ewen);
      end
      if (g) begin dp = 0; MemRead = 0; MemWrite = 0; end
      else begin ip = 0; Inst_Req_Valid = 0; end
      idx = int'(ea[5:2]);
      if (ewen) begin
        ref_mem[idx] = merge(ref_mem[idx], wd, ws);
      end else begin
        for (int r = $urandom_range(0, 2); r > 0; r--) tick();
        mem_rvalid = 1; mem_rdata = dmem[ra[5:2]];
        tick();
        mem_rvalid = 0;
        exp_d = ref_mem[idx];
        for (int a = $urandom_range(0, 3); a >= 0; a--) begin
          n_chk++;
          if (g ? (Read_data_Valid !== 1 || Inst_Valid !== 0 || Read_data !== exp_d)
                : (Inst_Valid !== 1 || Read_data_Valid !== 0 || Instruction !== exp_d)) begin
            n_fail++; $display("FAIL rnd_resp%0d: ivalid=%b dvalid=%b inst=%h rdata=%h required owner %0d data %h",
                               t, Inst_Valid, Read_data_Valid, Instruction, Read_data, g, exp_d);
          end
          if (a == 0) begin
            if (g) Read_data_Ack = 1; else Inst_Ack = 1;
          end
          tick();
        end
        Read_data_Ack = 0; Inst_Ack = 0;
        n_chk++;
        if ({Inst_Valid, Read_data_Valid} !== 2'b00) begin
          n_fail++; $display("FAIL rnd_consume%0d: ivalid/dvalid=%b required 00", t, {Inst_Valid, Read_data_Valid});
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_round_robin();
    test_backpressure();
    test_slow_consumer();
    test_reset_rwait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
